// File: rtl/mult_hilo_seq.sv
// mult_hilo_seq: MULTU sequencer for the shift-add multiplier, with the HI/LO register file and pipeline stall.
module mult_hilo_seq #(
    parameter int ITER = 32,
    parameter int CW   = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        mfhi_i,
    input  logic        mflo_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    output logic        mul_rst_o,
    output logic        mul_signal_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [63:0] mul_prod_i,
    output logic [31:0] rdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, OUT, CAPT} state_t;
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
    // CAPT is not busy, so it accepts a new issue exactly like IDLE for back-to-back throughput.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE, CAPT: begin
                state_d = start_i ? LOAD : IDLE;
                if (start_i) begin
                    a_d = op_a_i;
                    b_d = op_b_i;
                end else begin
                    hi_d = mthi_i ? wdata_i : hi_q;
                    lo_d = mtlo_i ? wdata_i : lo_q;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(ITER - 1)) ? OUT : RUN;
            end
            OUT: begin
                {hi_d, lo_d} = mul_prod_i;
                state_d      = CAPT;
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy_o       = (state_q == LOAD) || (state_q == RUN) || (state_q == OUT);
    assign stall_o      = busy_o & (start_i | mfhi_i | mflo_i | mthi_i | mtlo_i);
    assign mul_rst_o    = !rst_ni || (state_q == LOAD);
    assign mul_signal_o = (state_q == RUN);
    assign done_o       = (state_q == CAPT);
    assign mul_a_o      = a_q;
    assign mul_b_o      = b_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign rdata_o      = mfhi_i ? hi_q : (mflo_i ? lo_q : 32'h0);
endmodule

// File: tb/tb_mult_hilo_seq.sv
// tb_mult_hilo_seq: random and directed MULTU/MTxx/MFxx traffic against a shift-add multiplier model and a*b reference.
module tb_mult_hilo_seq;
    logic        clk = 0, rst_ni = 0;
    logic        start_i = 0, mfhi_i = 0, mflo_i = 0, mthi_i = 0, mtlo_i = 0;
    logic [31:0] op_a_i = 0, op_b_i = 0, wdata_i = 0;
    logic        mul_rst_o, mul_signal_o, busy_o, stall_o, done_o;
    logic [31:0] mul_a_o, mul_b_o, rdata_o, hi_o, lo_o;
    logic [63:0] mul_prod_i = 0;
    logic [63:0] acc = 0;
    logic [31:0] ma = 0, mb = 0;
    int          it = 0;
    int          n_pass = 0, n_total = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0;

    mult_hilo_seq dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .mfhi_i(mfhi_i), .mflo_i(mflo_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i),
        .mul_rst_o(mul_rst_o), .mul_signal_o(mul_signal_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_prod_i(mul_prod_i), .rdata_o(rdata_o), .hi_o(hi_o), .lo_o(lo_o),
        .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Environment multiplier: works on the negedge, one partial product per Signal=1 cycle.
    always @(negedge clk) begin
        if (mul_rst_o) begin
            acc = 0; ma = mul_a_o; mb = mul_b_o; it = 0;
        end else if (mul_signal_o) begin
            if (it < 32 && mb[it]) acc = acc + ({32'h0, ma} << it);
            it++;
        end else mul_prod_i = acc;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) $display("FAIL %s: got %h expected %h", tag, got, want);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit intr);
        logic [63:0] p;
        int n, sig;
        p = 64'(a) * 64'(b);
        start_i = 1; op_a_i = a; op_b_i = b;
        step();
        start_i = 0;
        #1;
        chk("load_rst", mul_rst_o, 1);
        chk("load_done", done_o, 0);
        n = 1; sig = 0;
        while (!done_o && n < 60) begin
            sig += int'(mul_signal_o);
            if (intr && n >= 10 && n < 15) begin
                start_i = 1; op_a_i = 7; op_b_i = 7; mfhi_i = 1; mtlo_i = 1; wdata_i = $urandom;
                #1;
                chk("busy_stall", stall_o, 1);
                chk("busy_rdata", rdata_o, exp_hi);
                chk("busy_mula", mul_a_o, a);
            end else if (intr && n == 15) begin
                start_i = 0; mfhi_i = 0; mtlo_i = 0;
                chk("busy_lo_kept", lo_o, exp_lo);
            end
            step();
            n++;
        end
        chk("latency", n, 35);
        chk("sig_cycles", sig, 32);
        chk("hi", hi_o, p[63:32]);
        chk("lo", lo_o, p[31:0]);
        {exp_hi, exp_lo} = p;
    endtask

    initial begin
        int dn;
        logic [31:0] w;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mulrst", mul_rst_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_hilo", {hi_o, lo_o}, 0);
        chk("rst_done", done_o, 0);
        rst_ni = 1;
        step();
        chk("idle_mulrst", mul_rst_o, 0);

        run_mul(3, 5, 0);
        mflo_i = 1; #1;
        chk("rd_lo", rdata_o, 32'hF);
        mflo_i = 0;
        step();
        chk("one_done", done_o, 0);

        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        mfhi_i = 1; #1;
        chk("rd_hi", rdata_o, 32'hFFFFFFFE);
        mfhi_i = 0;
        step();

        run_mul(32'h00012345, 32'h0000ABCD, 1);
        chk("after_start_busy", busy_o, 0);
        step();
        chk("held_start_ignored", busy_o, 0);

        mthi_i = 1; mfhi_i = 1; wdata_i = 32'h12345678; #1;
        chk("mthi_prewrite", rdata_o, exp_hi);
        step();
        mthi_i = 0; #1;
        chk("mthi_rd", rdata_o, 32'h12345678);
        mfhi_i = 0;
        exp_hi = 32'h12345678;

        start_i = 1; op_a_i = 9; op_b_i = 9; mthi_i = 1; wdata_i = 32'hDEADBEEF;
        step();
        start_i = 0; mthi_i = 0;
        chk("start_prio_hi", hi_o, exp_hi);
        repeat (11) step();
        rst_ni = 0; #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_mulrst", mul_rst_o, 1);
        chk("mid_rst_hilo", {hi_o, lo_o}, 0);
        step();
        rst_ni = 1;
        exp_hi = 0; exp_lo = 0;
        dn = 0;
        repeat (40) begin step(); dn += int'(done_o); end
        chk("mid_rst_nodone", dn, 0);
        run_mul(2, 2, 0);
        step();

        run_mul(6, 7, 0);
        run_mul(32'h10000, 32'h10000, 0);
        step();
        chk("b2b_one_done", done_o, 0);

        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            mtlo_i = 1; wdata_i = w;
            step();
            mtlo_i = 0; mflo_i = 1; #1;
            chk("rnd_mtlo", rdata_o, w);
            mflo_i = 0;
            run_mul($urandom, (i == 0) ? 32'h0 : $urandom, 0);
            mfhi_i = 1; #1;
            chk("rnd_rdhi", rdata_o, exp_hi);
            mfhi_i = 0;
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mult_hilo_seq.md
Name: mult_hilo_seq

Overview:
- Sequencer and HI/LO register file directly upstream and downstream of the 32-iteration shift-add multiplier.
- Accepts MULTU from the EX stage, latches the operands, and drives the multiplier's reset and Signal lines for the exact cycle count.
- Captures the 64-bit product into HI/LO and serves MFHI/MFLO/MTHI/MTLO.
- Produces the pipeline stall while a multiply is in flight.

Parameters:
- ITER, 32, number of Signal=1 iterations driven to the multiplier (must equal operand width).
- CW, 6, iteration counter width (>= clog2(ITER+1)).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  MULTU issued this cycle (unsigned).
- op_a  in  32  multiplicand.
- op_b  in  32  multiplier.
- mfhi  in  1  read HI onto rdata.
- mflo  in  1  read LO onto rdata.
- mthi  in  1  write wdata into HI.
- mtlo  in  1  write wdata into LO.
- wdata  in  32  MTHI/MTLO data.
- mul_rst  out  1  to multiplier reset (active-high; loads operands, clears accumulator).
- mul_signal  out  1  to multiplier Signal (1=MULT iterate, 0=OUT).
- mul_a  out  32  latched operand A to multiplier dataA.
- mul_b  out  32  latched operand B to multiplier dataB.
- mul_prod  in  64  multiplier dataOut.
- rdata  out  32  HI/LO read data (combinational).
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  multiply in flight.
- stall  out  1  hold IF/ID/EX this cycle.
- done  out  1  one-cycle pulse when HI/LO updated by a multiply.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, cnt=0, hi=lo=0, mul_a=mul_b=0, done=0, busy=0.
  - mul_rst forced 1 while reset=0, so the multiplier accumulator clears.
- States: IDLE, LOAD, RUN, OUT, CAPT.
- mul_rst=1 only in LOAD (and during reset).
- mul_signal=1 only in RUN; mul_signal=0 in all other states.
- IDLE:
  - start=1 latches op_a/op_b into mul_a/mul_b and goes to LOAD.
  - start has priority over mthi/mtlo in the same cycle; mthi/mtlo are ignored.
- LOAD: 1 cycle, multiplier loads operands; cnt<=0; go to RUN.
- RUN:
  - cnt increments each cycle.
  - When cnt==ITER-1, go to OUT. RUN lasts exactly ITER cycles, giving ITER multiplier negedges with Signal=1.
- OUT: 1 cycle, Signal=0; the multiplier copies its accumulator to dataOut on the mid-cycle negedge. Go to CAPT.
- CAPT:
  - At the posedge entering CAPT, {hi,lo}<=mul_prod.
  - done=1 for this cycle; next state IDLE.
- Latency: start sampled at posedge P0 → LOAD cycle 1, RUN cycles 2..33, OUT cycle 34, HI/LO valid and done=1 in cycle 35. A new start is accepted in cycle 35's IDLE-return edge, i.e. back-to-back issue every 35 cycles.
- busy=1 in LOAD, RUN, OUT; busy=0 in IDLE and CAPT.
- stall = busy & (start|mfhi|mflo|mthi|mtlo), combinational.
  - While busy, start/mthi/mtlo are ignored (no state change, operands not re-latched); the upstream holds the instruction until stall drops.
- rdata = mfhi ? hi : (mflo ? lo : 0). mfhi has priority if both are asserted. During busy, rdata shows the old HI/LO, but stall is asserted so the value is not consumed.
- MTHI/MTLO in IDLE write on the posedge; a same-cycle mfhi/mflo returns the pre-write value.
- mul_a/mul_b hold stable from LOAD through OUT.
- Reset mid-operation: immediate return to IDLE; hi/lo=0; the partial product is discarded; no done pulse.
- Product arithmetic is unsigned 32x32→64; HI=product[63:32], LO=product[31:0].

Test Plan:
- Reset low 2 cycles, then start op_a=3 op_b=5 → mul_rst=1 in cycle 1; mul_signal=1 for exactly 32 cycles; done in cycle 35; hi=0x00000000, lo=0x0000000F; mflo → rdata=0xF.
- start op_a=0xFFFFFFFF op_b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 at cycle 35; mfhi → rdata=0xFFFFFFFE.
- During RUN, assert start with op_a=7 op_b=7 and mfhi → stall=1 each cycle, operands unchanged, final product still from the first operands; the second start is accepted only after busy drops.
- mthi wdata=0x12345678 in IDLE, then mfhi next cycle → rdata=0x12345678; mtlo while busy → stall=1, lo unchanged.
- Drop reset to 0 at RUN cnt=10 → state IDLE, hi=lo=0, busy=0, mul_rst=1 during reset, no done; a fresh start of 2*2 afterwards gives lo=4.
- Back-to-back: start 6*7 then start 0x10000*0x10000 on the first free cycle → lo=42, then hi=0x00000001 lo=0x00000000; each produces exactly one done pulse.
